// File: rtl/de_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// de_ex_pipe_reg
//   Decode -> Execute pipeline register. Captures the decoded control bundle,
//   the operands, the immediate, rd and pc. It presents them to Execute one
//   cycle after they are accepted from Decode.
//
//   Optional feature macro: DE_EX_SKID_EN
//     defined   : two entries (main + skid). in_ready is a registered decode of
//                 the state (no combinational path from out_ready). This keeps
//                 full throughput when a stall is released.
//     undefined : a single entry. in_ready = !out_valid | out_ready
//                 (combinational). There is no TWO state and no skid registers.
//
//   Handshake: a beat moves on a side when valid and ready are both high at
//   the rising clock edge. Accept = in_valid & in_ready. Transfer =
//   out_valid & out_ready. Once out_valid is asserted, it and the out_*
//   payload stay stable until the transfer completes, unless flush or reset
//   kills the entry.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous kill of held and incoming entries;
//                         a transfer in the same cycle still completes
//   in_valid / in_ready   Decode-side handshake
//   in_pc .. in_MEM_REG   decoded payload from Decode
//   out_valid / out_ready Execute-side handshake
//   out_pc .. out_MEM_REG registered payload. out_MEM_WE, out_DE_WE and
//                         out_BRN_COND are forced low while out_valid is low.
//   fsm_state             debug view of the occupancy state
//                         (0 EMPTY, 1 ONE, 2 TWO)
// -----------------------------------------------------------------------------
module de_ex_pipe_reg #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RA_W-1:0] in_rd,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_ALU_OP,
    input  logic [1:0]      in_ALU_SRC2,
    input  logic            in_BRN_COND,
    input  logic            in_MEM_WE,
    input  logic            in_DE_WE,
    input  logic            in_MEM_REG,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [RA_W-1:0] out_rd,
    output logic [2:0]      out_funct3,
    output logic [1:0]      out_ALU_OP,
    output logic [1:0]      out_ALU_SRC2,
    output logic            out_BRN_COND,
    output logic            out_MEM_WE,
    output logic            out_DE_WE,
    output logic            out_MEM_REG,
    output logic [1:0]      fsm_state
);

    // Payload is carried as one flat vector so the main and skid entries
    // share a single packing order.
    localparam int PW = 4*XLEN + RA_W + 11;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] in_bus;
    logic [PW-1:0] main_q;
    logic          take;
    logic          xfer;
    logic          load_main;
    logic          main_from_skid;
    logic          load_skid;
    logic          brn_q, mem_we_q, de_we_q;

    assign in_bus = {in_pc, in_rs1, in_rs2, in_imm, in_rd, in_funct3,
                     in_ALU_OP, in_ALU_SRC2, in_BRN_COND, in_MEM_WE,
                     in_DE_WE, in_MEM_REG};

    assign out_valid = (state_q != S_EMPTY);
    assign fsm_state = state_q;
    assign xfer      = out_valid & out_ready;
    // An accept that coincides with flush is discarded; it must not load.
    assign take      = in_valid & in_ready & ~flush;

`ifdef DE_EX_SKID_EN
    logic [PW-1:0] skid_q;
    // Registered ready: only a full skid entry blocks Decode.
    assign in_ready = (state_q != S_TWO);
`else
    // Single entry: can take a new beat if empty or if the held beat leaves
    // this same cycle.
    assign in_ready = (state_q == S_EMPTY) | out_ready;
`endif

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (take) begin
                    state_d   = S_ONE;
                    load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (xfer && take) begin
                    load_main = 1'b1;
                end else if (xfer) begin
                    state_d = S_EMPTY;
`ifdef DE_EX_SKID_EN
                end else if (take) begin
                    state_d   = S_TWO;
                    load_skid = 1'b1;
`endif
                end
            end
`ifdef DE_EX_SKID_EN
            S_TWO: begin
                if (xfer) begin
                    state_d        = S_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
`endif
            default: state_d = S_EMPTY;
        endcase
        // Flush overrides everything. Any beat presented on the output this
        // cycle is still consumed by Execute (xfer), but nothing survives.
        if (flush) begin
            state_d        = S_EMPTY;
            load_main      = 1'b0;
            main_from_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
`ifdef DE_EX_SKID_EN
                main_q <= main_from_skid ? skid_q : in_bus;
`else
                main_q <= in_bus;
`endif
            end
        end
    end

`ifdef DE_EX_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (flush) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_bus;
        end
    end
`else
    // No skid storage in this build; the promote/skid strobes are unused.
    logic unused_skid;
    assign unused_skid = main_from_skid | load_skid;
`endif

    assign {out_pc, out_rs1, out_rs2, out_imm, out_rd, out_funct3,
            out_ALU_OP, out_ALU_SRC2, brn_q, mem_we_q, de_we_q,
            out_MEM_REG} = main_q;

    // Side-effecting controls are gated so a stale entry can never fire a
    // branch, store or writeback.
    assign out_BRN_COND = brn_q    & out_valid;
    assign out_MEM_WE   = mem_we_q & out_valid;
    assign out_DE_WE    = de_we_q  & out_valid;

endmodule
